uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the serial frame data bit count.
REQ-002 CLK  input  1  transmit bit clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to send.
REQ-005 DATA_VALID  input  1  byte-available strobe.
REQ-006 PAR_EN  input  1  1 = insert parity bit.
REQ-007 PAR_TYP  input  1  parity type, forwarded to the parity unit.
REQ-008 par_bit  input  1  registered parity result returned by the parity unit.
REQ-009 par_data  output  DATA_WIDTH  latched byte driven to the parity unit.
REQ-010 par_dv  output  1  one-cycle parity-compute strobe.
REQ-011 par_typ  output  1  latched PAR_TYP driven to the parity unit.
REQ-012 TX_OUT  output  1  serial line, idle high.
REQ-013 Busy  output  1  frame in progress.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP (plus STOP2, see Configuration).
REQ-015 Accept: in IDLE, or in the final stop cycle, with DATA_VALID=1 at a rising edge, the block SHALL latch P_DATA into par_data, PAR_EN and PAR_TYP into internal/par_typ registers, and assert par_dv for exactly that following cycle.
REQ-016 The state after accept SHALL be START for 1 cycle with TX_OUT=0.
REQ-017 DATA SHALL last DATA_WIDTH cycles, driving par_data bits LSB first, sequenced by a counter from 0 to DATA_WIDTH-1.
REQ-018 If latched PAR_EN=1, PARITY SHALL follow for 1 cycle with TX_OUT=par_bit; otherwise DATA goes directly to STOP.
REQ-019 STOP SHALL last 1 cycle with TX_OUT=1, then go to IDLE, or to START if an accept occurs (back-to-back, no idle gap).
REQ-020 TX_OUT and Busy SHALL be registered, updating on the same edge as the state.
REQ-021 Busy SHALL be 0 in IDLE and 1 in all other states.
REQ-022 DATA_VALID SHALL be ignored in START, DATA and PARITY, and in STOP when STOP2 is compiled in.
REQ-023 Changes on P_DATA, PAR_EN or PAR_TYP after accept SHALL NOT affect the frame in progress.
REQ-024 Frame length SHALL be 2+DATA_WIDTH+PAR_EN cycles, or one more with STOP2.
REQ-025 The bit counter SHALL saturate/reset to 0 on leaving DATA; it SHALL never wrap inside a frame.

Reset
REQ-026 On RST=0, outputs SHALL immediately be TX_OUT=1, Busy=0, par_dv=0, par_data=0, par_typ=0; state SHALL be IDLE and the counter 0.
REQ-027 Reset mid-frame SHALL abort the frame with no further line activity; the first post-reset edge with DATA_VALID=1 SHALL be a normal accept.

Configuration
REQ-028 With macro UART_TX_TWO_STOP_EN defined, the block SHALL insert state STOP2 (TX_OUT=1, 1 cycle) after STOP. The accept/back-to-back window SHALL move from STOP to STOP2.
REQ-029 Without UART_TX_TWO_STOP_EN, STOP2 SHALL not exist and STOP SHALL be the final stop cycle.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=0, DATA_VALID pulsed 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high for 10 cycles.
REQ-031 P_DATA=0x03, PAR_EN=1, parity unit attached -> par_dv single pulse after accept; 11-cycle frame; parity cycle equals par_bit for the configured PAR_TYP.
REQ-032 DATA_VALID held high with 0x55 then 0xAA -> two frames with no idle cycle between STOP and the next START; Busy never drops.
REQ-033 P_DATA changed to 0xFF and DATA_VALID pulsed during DATA -> ignored; current frame bits unchanged.
REQ-034 RST asserted at the 4th data bit -> TX_OUT=1 and Busy=0 asynchronously; next DATA_VALID starts a clean frame.
REQ-035 With UART_TX_TWO_STOP_EN defined, P_DATA=0x00, PAR_EN=0 -> 11-cycle frame ending 1,1; back-to-back accept only in STOP2.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte-source, parity-unit and line signals of the UART transmit controller.
// Latency: none, wires only.
// Backpressure: none carried here; Busy plus the accept window tell the source when a byte is taken.
// Ports: P_DATA/DATA_VALID/PAR_EN/PAR_TYP come from the byte source.
//        par_bit comes from the parity unit; par_data/par_dv/par_typ go to it.
//        TX_OUT/Busy are the serial line and the frame-in-progress flag.
// Modports: slave = transmitter, master = environment (byte source plus parity unit).
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  par_bit;
  logic [DATA_WIDTH-1:0] par_data;
  logic                  par_dv;
  logic                  par_typ;
  logic                  TX_OUT;
  logic                  Busy;

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, par_bit,
    output par_data, par_dv, par_typ, TX_OUT, Busy
  );

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, par_bit,
    input  par_data, par_dv, par_typ, TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit framing FSM (start bit, data LSB first, optional parity, stop).
// Latency: TX_OUT drops to the start bit the cycle after an accept; a frame lasts 2+DATA_WIDTH+PAR_EN cycles.
//          With UART_TX_TWO_STOP_EN defined, a second stop bit adds one cycle.
// Backpressure: none; DATA_VALID is taken only in IDLE or the final stop cycle and ignored otherwise.
// Ports: CLK (bit clock), RST (async, active-low), bus (uart_tx_ctrl_if.slave).
//        bus carries P_DATA/DATA_VALID/PAR_EN/PAR_TYP in, par_bit in from the parity unit,
//        par_data/par_dv/par_typ out to the parity unit, and TX_OUT/Busy out.
// Build option: `define UART_TX_TWO_STOP_EN adds STOP2 and moves the accept window from STOP to STOP2.
// DATA_WIDTH must match the DATA_WIDTH of the connected interface instance.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] par_data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_dv_q;
  logic                  tx_q;
  logic                  busy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      par_data_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_dv_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // The parity strobe is a single-cycle pulse; only an accept re-raises it.
      par_dv_q <= 1'b0;
      case (state_q)
        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          tx_q    <= par_data_q[0];
        end

        DATA: begin
          if (cnt_q == LAST_BIT) begin
            // Counter is parked at 0 on the way out so it never wraps mid-frame.
            cnt_q <= '0;
            if (par_en_q) begin
              // par_dv fired during START, so the parity unit's registered result is settled.
              state_q <= PARITY;
              tx_q    <= bus.par_bit;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            tx_q  <= par_data_q[cnt_q + 1'b1];
          end
        end

        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end

`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          state_q <= STOP2;
          tx_q    <= 1'b1;
        end

        IDLE, STOP2: begin
`else
        IDLE, STOP: begin
`endif
          // Accept window: idle, or the last stop cycle for back-to-back frames.
          if (bus.DATA_VALID) begin
            state_q    <= START;
            par_data_q <= bus.P_DATA;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            par_dv_q   <= 1'b1;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.par_data = par_data_q;
  assign bus.par_typ  = par_typ_q;
  assign bus.par_dv   = par_dv_q;
  assign bus.TX_OUT   = tx_q;
  assign bus.Busy     = busy_q;

endmodule
